// File: rtl/add_state_process_pkg.sv
// Shared definitions for the add stage: operand field positions, opcodes, idle encodings.
// lz_AddState is produced only when ADD_STATE_LZC_EN is defined.
package add_state_process_pkg;

  localparam int SIGN_BIT = 35;
  localparam int EXP_MSB  = 34;
  localparam int EXP_LSB  = 27;
  localparam int MAN_MSB  = 26;
  localparam int MAN_LSB  = 0;

  localparam logic [3:0] SIN_COS     = 4'd0;
  localparam logic [3:0] SINH_COSH   = 4'd1;
  localparam logic [3:0] ARCTAN      = 4'd2;
  localparam logic [3:0] ARCTANH     = 4'd3;
  localparam logic [3:0] EXPONENTIAL = 4'd4;
  localparam logic [3:0] SQR_ROOT    = 4'd5;
  localparam logic [3:0] DIVISION    = 4'd6;
  localparam logic [3:0] TANGENT     = 4'd7;
  localparam logic [3:0] TANH        = 4'd8;
  localparam logic [3:0] NAT_LOG     = 4'd9;
  localparam logic [3:0] HYPOTENUSE  = 4'd10;
  localparam logic [3:0] PRE_PROCESS = 4'd11;

  localparam logic NO_IDLE  = 1'b0;
  localparam logic PUT_IDLE = 1'b1;

endpackage

// File: rtl/add_state_process_lzc.sv
// Combinational leading-zero count of a 27-bit magnitude, saturating at 27 for zero.
module leading_zero_count28 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit is the last assignment and wins.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/add_state_process.sv
// Two-stage add stage: S1 signed-magnitude add/subtract, S2 leading-zero count.
// Define ADD_STATE_LZC_EN to enable the leading-zero counter; otherwise lz_AddState is 0.
module add_state_process
  import add_state_process_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        idle_Allign,
  input  logic [35:0] cout_Allign,
  input  logic [35:0] zout_Allign,
  input  logic [31:0] sout_Allign,
  input  logic [3:0]  Opcode_Allign,
  input  logic [31:0] z_postAllign,
  input  logic [7:0]  InsTagAllign,
  output logic        idle_AddState,
  output logic        sign_AddState,
  output logic [7:0]  exp_AddState,
  output logic [27:0] sum_AddState,
  output logic [4:0]  lz_AddState,
  output logic [31:0] sout_AddState,
  output logic [3:0]  Opcode_AddState,
  output logic [31:0] z_postAddState,
  output logic [7:0]  InsTagAddState
);

  logic        z_sign, c_sign;
  logic [26:0] z_man, c_man;
  logic        add_sign;
  logic [27:0] add_sum;

  // The c exponent is redundant after alignment.
  logic unused_c_exp;
  assign unused_c_exp = ^cout_Allign[EXP_MSB:EXP_LSB];

  assign z_sign = zout_Allign[SIGN_BIT];
  assign c_sign = cout_Allign[SIGN_BIT];
  assign z_man  = zout_Allign[MAN_MSB:MAN_LSB];
  assign c_man  = cout_Allign[MAN_MSB:MAN_LSB];

  always_comb begin
    add_sign = 1'b0;
    add_sum  = '0;
    if (idle_Allign == NO_IDLE) begin
      if (z_sign == c_sign) begin
        add_sum  = {1'b0, z_man} + {1'b0, c_man};
        add_sign = z_sign;
      end else if (z_man >= c_man) begin
        add_sum  = {1'b0, z_man - c_man};
        add_sign = (z_man == c_man) ? 1'b0 : z_sign;
      end else begin
        add_sum  = {1'b0, c_man - z_man};
        add_sign = c_sign;
      end
    end
  end

  logic        s1_idle, s1_sign;
  logic [7:0]  s1_exp;
  logic [27:0] s1_sum;
  logic [31:0] s1_sout, s1_zpost;
  logic [3:0]  s1_opcode;
  logic [7:0]  s1_tag;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_idle   <= PUT_IDLE;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_sum    <= '0;
      s1_sout   <= '0;
      s1_opcode <= '0;
      s1_zpost  <= '0;
      s1_tag    <= '0;
    end else if (!stall) begin
      s1_idle   <= idle_Allign;
      s1_sign   <= add_sign;
      s1_exp    <= (idle_Allign == NO_IDLE) ? zout_Allign[EXP_MSB:EXP_LSB] : 8'd0;
      s1_sum    <= add_sum;
      s1_sout   <= sout_Allign;
      s1_opcode <= Opcode_Allign;
      s1_zpost  <= z_postAllign;
      s1_tag    <= InsTagAllign;
    end
  end

  logic [4:0] lz_next;

`ifdef ADD_STATE_LZC_EN
  logic [4:0] lzc_count;

  leading_zero_count28 u_lzc (
    .value (s1_sum[26:0]),
    .count (lzc_count)
  );

  // A carry-out means the magnitude already sits above bit 26.
  assign lz_next = s1_sum[27] ? 5'd0 : lzc_count;
`else
  assign lz_next = 5'd0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_AddState   <= PUT_IDLE;
      sign_AddState   <= 1'b0;
      exp_AddState    <= '0;
      sum_AddState    <= '0;
      lz_AddState     <= '0;
      sout_AddState   <= '0;
      Opcode_AddState <= '0;
      z_postAddState  <= '0;
      InsTagAddState  <= '0;
    end else if (!stall) begin
      idle_AddState   <= s1_idle;
      sign_AddState   <= s1_sign;
      exp_AddState    <= s1_exp;
      sum_AddState    <= s1_sum;
      lz_AddState     <= lz_next;
      sout_AddState   <= s1_sout;
      Opcode_AddState <= s1_opcode;
      z_postAddState  <= s1_zpost;
      InsTagAddState  <= s1_tag;
    end
  end

endmodule

// File: tb/tb_add_state_process.sv
// Directed bench for add_state_process: arithmetic vectors, idle pass-through, stall and reset.
module tb_add_state_process;

  logic        clock = 1'b0;
  logic        reset, stall;
  logic        idle_Allign;
  logic [35:0] cout_Allign, zout_Allign;
  logic [31:0] sout_Allign, z_postAllign;
  logic [3:0]  Opcode_Allign;
  logic [7:0]  InsTagAllign;
  logic        idle_AddState, sign_AddState;
  logic [7:0]  exp_AddState;
  logic [27:0] sum_AddState;
  logic [4:0]  lz_AddState;
  logic [31:0] sout_AddState, z_postAddState;
  logic [3:0]  Opcode_AddState;
  logic [7:0]  InsTagAddState;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clock = ~clock;

  add_state_process dut (
    .clock(clock), .reset(reset), .stall(stall),
    .idle_Allign(idle_Allign), .cout_Allign(cout_Allign), .zout_Allign(zout_Allign),
    .sout_Allign(sout_Allign), .Opcode_Allign(Opcode_Allign),
    .z_postAllign(z_postAllign), .InsTagAllign(InsTagAllign),
    .idle_AddState(idle_AddState), .sign_AddState(sign_AddState),
    .exp_AddState(exp_AddState), .sum_AddState(sum_AddState),
    .lz_AddState(lz_AddState), .sout_AddState(sout_AddState),
    .Opcode_AddState(Opcode_AddState), .z_postAddState(z_postAddState),
    .InsTagAddState(InsTagAddState)
  );

  function automatic logic [35:0] opnd(input logic s, input logic [7:0] e, input logic [26:0] m);
    return {s, e, m};
  endfunction

  // Expected lz for the configured build.
  function automatic logic [4:0] want_lz(input logic [4:0] v);
`ifdef ADD_STATE_LZC_EN
    return v;
`else
    return 5'd0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic idle, input logic sign,
                         input logic [7:0] e, input logic [27:0] sum, input logic [4:0] lz,
                         input logic [31:0] sout, input logic [3:0] op,
                         input logic [31:0] zp, input logic [7:0] itag);
    chk({tag, ".idle"},   {31'd0, idle_AddState},   {31'd0, idle});
    chk({tag, ".sign"},   {31'd0, sign_AddState},   {31'd0, sign});
    chk({tag, ".exp"},    {24'd0, exp_AddState},    {24'd0, e});
    chk({tag, ".sum"},    {4'd0, sum_AddState},     {4'd0, sum});
    chk({tag, ".lz"},     {27'd0, lz_AddState},     {27'd0, lz});
    chk({tag, ".sout"},   sout_AddState,            sout);
    chk({tag, ".opcode"}, {28'd0, Opcode_AddState}, {28'd0, op});
    chk({tag, ".zpost"},  z_postAddState,           zp);
    chk({tag, ".tag"},    {24'd0, InsTagAddState},  {24'd0, itag});
  endtask

  task automatic drive(input logic idle, input logic [35:0] z, input logic [35:0] c,
                       input logic [31:0] sout, input logic [3:0] op,
                       input logic [31:0] zp, input logic [7:0] itag);
    idle_Allign   = idle;
    zout_Allign   = z;
    cout_Allign   = c;
    sout_Allign   = sout;
    Opcode_Allign = op;
    z_postAllign  = zp;
    InsTagAllign  = itag;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b1, '0, '0, '0, '0, '0, '0);
    step();
    step();
    chk_out("reset", 1'b1, 1'b0, 8'h00, 28'h0, 5'd0, 32'h0, 4'h0, 32'h0, 8'h00);

    reset = 1'b0;
    // A: equal signs, carry out.
    drive(1'b0, opnd(1'b0, 8'h80, 27'h4000000), opnd(1'b0, 8'h80, 27'h4000000),
          32'hA0A0A0A0, 4'd2, 32'h11111111, 8'h11);
    step();
    // B: differing signs, z larger.
    drive(1'b0, opnd(1'b0, 8'h81, 27'h6000000), opnd(1'b1, 8'h81, 27'h2000000),
          32'hB0B0B0B0, 4'd5, 32'h22222222, 8'h12);
    step();
    chk_out("vecA", 1'b0, 1'b0, 8'h80, 28'h8000000, want_lz(5'd0),
            32'hA0A0A0A0, 4'd2, 32'h11111111, 8'h11);
    // C: exact cancellation.
    drive(1'b0, opnd(1'b0, 8'h7F, 27'h0000010), opnd(1'b1, 8'h7F, 27'h0000010),
          32'hC0C0C0C0, 4'd9, 32'h33333333, 8'h13);
    step();
    chk_out("vecB", 1'b0, 1'b0, 8'h81, 28'h4000000, want_lz(5'd0),
            32'hB0B0B0B0, 4'd5, 32'h22222222, 8'h12);
    // D: differing signs, c larger, result takes c sign.
    drive(1'b0, opnd(1'b1, 8'h7F, 27'h0000008), opnd(1'b0, 8'h7F, 27'h0000010),
          32'hD0D0D0D0, 4'd11, 32'h44444444, 8'h14);
    step();
    chk_out("vecC", 1'b0, 1'b0, 8'h7F, 28'h0, want_lz(5'd27),
            32'hC0C0C0C0, 4'd9, 32'h33333333, 8'h13);
    // E: idle entry with live-looking operands.
    drive(1'b1, opnd(1'b1, 8'h90, 27'h1234567), opnd(1'b1, 8'h90, 27'h0000001),
          32'h3F800000, 4'd0, 32'h55555555, 8'h5A);
    step();
    chk_out("vecD", 1'b0, 1'b0, 8'h7F, 28'h8, want_lz(5'd23),
            32'hD0D0D0D0, 4'd11, 32'h44444444, 8'h14);
    // F: negative sum with no carry.
    drive(1'b0, opnd(1'b1, 8'h10, 27'h0100000), opnd(1'b1, 8'h10, 27'h0100000),
          32'hF0F0F0F0, 4'd7, 32'h66666666, 8'h15);
    step();
    chk_out("vecE_idle", 1'b1, 1'b0, 8'h00, 28'h0, want_lz(5'd27),
            32'h3F800000, 4'd0, 32'h55555555, 8'h5A);
    step();
    chk_out("vecF", 1'b0, 1'b1, 8'h10, 28'h0200000, want_lz(5'd5),
            32'hF0F0F0F0, 4'd7, 32'h66666666, 8'h15);

    // Stall: tags 1,2 enter, three stalled cycles with junk inputs, then tag 3.
    drive(1'b0, opnd(1'b0, 8'h80, 27'h4000000), opnd(1'b0, 8'h80, 27'h4000000),
          32'h1, 4'd1, 32'h1, 8'h01);
    step();
    drive(1'b0, opnd(1'b0, 8'h81, 27'h6000000), opnd(1'b1, 8'h81, 27'h2000000),
          32'h2, 4'd2, 32'h2, 8'h02);
    step();
    chk_out("stream_t1", 1'b0, 1'b0, 8'h80, 28'h8000000, want_lz(5'd0),
            32'h1, 4'd1, 32'h1, 8'h01);
    stall = 1'b1;
    drive(1'b0, opnd(1'b1, 8'hEE, 27'h0000001), opnd(1'b1, 8'hEE, 27'h0000001),
          32'h99, 4'd9, 32'h99, 8'h99);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall_hold", 1'b0, 1'b0, 8'h80, 28'h8000000, want_lz(5'd0),
              32'h1, 4'd1, 32'h1, 8'h01);
    end
    stall = 1'b0;
    drive(1'b0, opnd(1'b1, 8'h7F, 27'h0000008), opnd(1'b0, 8'h7F, 27'h0000010),
          32'h3, 4'd3, 32'h3, 8'h03);
    step();
    chk_out("stream_t2", 1'b0, 1'b0, 8'h81, 28'h4000000, want_lz(5'd0),
            32'h2, 4'd2, 32'h2, 8'h02);
    drive(1'b1, '0, '0, '0, '0, '0, 8'h00);
    step();
    chk_out("stream_t3", 1'b0, 1'b0, 8'h7F, 28'h8, want_lz(5'd23),
            32'h3, 4'd3, 32'h3, 8'h03);

    // Reset with two entries in flight and stall asserted.
    drive(1'b0, opnd(1'b0, 8'h80, 27'h4000000), opnd(1'b0, 8'h80, 27'h4000000),
          32'hAA, 4'd4, 32'hAA, 8'hAA);
    step();
    drive(1'b0, opnd(1'b0, 8'h81, 27'h6000000), opnd(1'b1, 8'h81, 27'h2000000),
          32'hBB, 4'd6, 32'hBB, 8'hBB);
    step();
    reset = 1'b1;
    stall = 1'b1;
    step();
    chk_out("reset_stall", 1'b1, 1'b0, 8'h00, 28'h0, 5'd0, 32'h0, 4'h0, 32'h0, 8'h00);
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, opnd(1'b0, 8'h80, 27'h4000000), opnd(1'b0, 8'h80, 27'h4000000),
          32'h77, 4'd8, 32'h77, 8'h77);
    step();
    chk_out("post_reset_1clk", 1'b1, 1'b0, 8'h00, 28'h0, 5'd0, 32'h0, 4'h0, 32'h0, 8'h00);
    drive(1'b1, '0, '0, '0, '0, '0, 8'h00);
    step();
    chk_out("post_reset_2clk", 1'b0, 1'b0, 8'h80, 28'h8000000, want_lz(5'd0),
            32'h77, 4'd8, 32'h77, 8'h77);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/add_state_process.md
ADD_STATE_PROCESS -- requirements
Module: AddStateProcess

Interface
REQ-001 Parameters: none; all widths fixed by the shared package.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on rising clock.
REQ-004 stall  input  1  when 1, all pipeline registers hold their values.
REQ-005 idle_Allign, cout_Allign[35:0], zout_Allign[35:0], sout_Allign[31:0], Opcode_Allign[3:0], z_postAllign[31:0], InsTagAllign[7:0]  inputs  from the align stage; operand format {sign[35], biased exp[34:27], mantissa[26:0] with hidden bit at 26 and guard/round/sticky at 2:0}.
REQ-006 idle_AddState  output  1  idle flag, delayed.
REQ-007 sign_AddState  output  1  result sign.
REQ-008 exp_AddState  output  8  biased result exponent.
REQ-009 sum_AddState  output  28  unnormalised magnitude, bit 27 = carry-out.
REQ-010 lz_AddState  output  5  leading-zero count of sum_AddState[26:0].
REQ-011 sout_AddState[31:0], Opcode_AddState[3:0], z_postAddState[31:0], InsTagAddState[7:0]  outputs  sideband, delayed.

Function
REQ-012 Two-stage pipeline: S1 add/subtract, S2 leading-zero count; latency exactly 2 clocks from input sample to output.
REQ-013 Sideband (idle, sout, Opcode, z_post, InsTag) shall travel through both stages unchanged and aligned with its operands.
REQ-014 S1, idle=0, equal signs: sum = {0,zm}+{0,cm} (28 bits), sign = z sign.
REQ-015 S1, idle=0, differing signs, zm >= cm: sum = zm-cm, sign = z sign; zm < cm: sum = cm-zm, sign = c sign.
REQ-016 Exact cancellation (differing signs, zm==cm) shall yield sum=0, sign=0.
REQ-017 S1 exponent = zout_Allign[34:27] (operands already aligned; c exponent ignored).
REQ-018 S1, idle=1: sum=0, sign=0, exp=0; sideband still propagates.
REQ-019 S2 registers S1 result unchanged and lz = number of leading zeros in sum[26:0] from bit 26, saturating at 27 when sum[26:0]==0; lz=0 when sum[27]=1.
REQ-020 stall=1 freezes S1 and S2 registers; inputs presented during stall are discarded (upstream must hold).
REQ-021 stall deasserting resumes with no lost or duplicated entry.
REQ-022 reset and stall both asserted: reset wins.

Reset
REQ-023 On reset all outputs and internal stage registers clear to 0, except idle_AddState and the S1 idle register, which set to 1.
REQ-024 Reset mid-operation discards both in-flight entries; first valid output appears 2 clocks after first post-reset input sample.

Configuration
REQ-025 Macro ADD_STATE_LZC_EN defined: lz_AddState computed per REQ-019.
REQ-026 ADD_STATE_LZC_EN undefined: no counter logic; lz_AddState tied to 0; latency and all other outputs unchanged.

Structure
REQ-027 Shared package holds operand field positions (sign 35, exp 34:27, mantissa 26:0), opcode constants (sin_cos=0 ... PreProcess=11), idle encodings (no_idle=0, put_idle=1).
REQ-028 One sub-module LeadingZeroCount28 (combinational, 27-bit in, 5-bit out), instantiated only under ADD_STATE_LZC_EN.

Verification
REQ-029 z={0,0x80,0x4000000}, c={0,0x80,0x4000000}, idle=0 -> after 2 clocks sum=0x8000000, sign=0, exp=0x80, lz=0.
REQ-030 z={0,0x81,0x6000000}, c={1,0x81,0x2000000} -> sum=0x4000000, sign=0, exp=0x81, lz=0 (with LZC_EN).
REQ-031 z={0,0x7F,0x0000010}, c={1,0x7F,0x0000010} -> sum=0, sign=0, lz=27; repeat with z={1,...,0x0000008}, c={0,...,0x0000010} -> sum=0x8, sign=0.
REQ-032 idle=1, sout=0x3F800000, InsTag=0x5A -> after 2 clocks idle=1, sum=0, sout=0x3F800000, InsTag=0x5A.
REQ-033 Stream tags 1,2,3 with stall=1 for 3 cycles after tag 2 enters -> outputs show tags 1,2,3 in order, no duplicates, outputs constant during stall.
REQ-034 Assert reset with two entries in flight (stall=1 simultaneously) -> next clock all outputs 0, idle_AddState=1.
